// File: rtl/key_seq_pkg.sv
// Shared types and constants for the key pattern self-test sequencer.
// Holds the FSM state enum and the expected-table lookup helper.
package key_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int PATTERN_CNT = 4;
  localparam int KEY_W       = 2;
  localparam int ERR_W       = 3;

  function automatic logic [KEY_W-1:0] expect_entry(
    input logic [KEY_W*PATTERN_CNT-1:0] tbl,
    input logic [KEY_W-1:0]             idx
  );
    return tbl[{idx, 1'b0} +: KEY_W];
  endfunction

endpackage

// File: rtl/key_pattern_sequencer_dwell_timer.sv
// Loadable down-counter with a zero flag; paces each pattern's dwell.
// Decrement saturates at zero so a stray enable cannot wrap.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/key_pattern_sequencer.sv
// Self-test sequencer stepping key_sw through 00..11 and checking led_i.
// Optional LED_SYNC_EN adds a 2-flop synchronizer on led_i.
module key_pattern_sequencer
  import key_seq_pkg::*;
#(
  parameter int              DWELL  = 10,
  parameter logic [7:0]      EXPECT = 8'b11100100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] led_i,
  output logic [KEY_W-1:0] key_sw_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [KEY_W-1:0] fail_idx
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(PATTERN_CNT - 1);

  if ((DWELL < 1) || (DWELL > 65535)) begin : g_dwell_range
    $error("DWELL must be in 1..65535");
  end

  state_t           r_state;
  logic [KEY_W-1:0] r_idx;
  logic [KEY_W-1:0] r_key;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [KEY_W-1:0] r_fail;

  logic             w_led;
  logic [KEY_W-1:0] w_led_cmp;
  logic             w_zero;
  logic             w_load;
  logic             w_dec;
  logic             w_mis;
  logic [ERR_W-1:0] w_err_next;

`ifdef LED_SYNC_EN
  if (DWELL < 3) begin : g_sync_dwell
    $error("DWELL must be >= 3 with LED_SYNC_EN");
  end

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= led_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_led_cmp = r_sync2;
`else
  assign w_led_cmp = led_i;
`endif

  assign w_led = 1'b1;
  assign w_load = (r_state == APPLY);
  assign w_dec  = (r_state == WAIT) && !w_zero;
  assign w_mis  = w_led &&
                  (w_led_cmp != expect_entry(EXPECT, r_idx));
  assign w_err_next = r_err + ERR_W'(w_mis);

  dwell_timer #(
    .W (CW)
  ) u_dwell_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (CW'(DWELL - 1)),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_key   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_key <= '0;
          if (start) begin
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          r_key   <= r_idx;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_zero) r_state <= CHECK;
        end
        CHECK: begin
          r_err <= w_err_next;
          if (w_mis && (r_err == '0)) r_fail <= r_idx;
          // Last pattern exits before the index could wrap
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_key   <= '0;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= APPLY;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_sw_o = r_key;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_idx = r_fail;

endmodule

// File: tb/tb_key_pattern_sequencer.sv
// Randomized self-checking bench for key_pattern_sequencer.
// LED response is key_sw_o XOR a per-pattern corruption mask.
module tb_key_pattern_sequencer;

`ifdef LED_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 4;
`endif
  localparam int LAT = 4 * (D + 2) + 1;
  localparam logic [7:0] EXP_TBL = 8'b11100100;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] led_i;
  logic [1:0] key_sw_o;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_idx;
  logic [7:0] masks;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign led_i = key_sw_o ^ masks[{key_sw_o, 1'b0} +: 2];

  key_pattern_sequencer #(
    .DWELL  (D),
    .EXPECT (EXP_TBL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .led_i    (led_i),
    .key_sw_o (key_sw_o),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
  );

  function automatic void model(input logic [7:0] m, output int e,
                                output int f, output logic p);
    int seen;
    int want;
    e = 0;
    f = 0;
    for (int i = 0; i < 4; i++) begin
      seen = i ^ int'(m[2*i +: 2]);
      want = int'((EXP_TBL >> (2 * i)) & 8'h03);
      if (seen != want) begin
        if (e == 0) f = i;
        e++;
      end
    end
    p = (e == 0);
  endfunction

  task automatic do_run(input logic [7:0] m, output int dcyc,
                        output int key_bad, output int busy_bad,
                        output logic p, output logic [2:0] e,
                        output logic [1:0] f, output logic [1:0] key_after,
                        output logic busy_after);
    int k;
    dcyc = 0; key_bad = 0; busy_bad = 0;
    p = 0; e = 0; f = 0; key_after = 0; busy_after = 0;
    @(negedge clk);
    masks = m;
    start = 1'b1;
    k = 0;
    while (dcyc == 0 && k < 200) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy !== 1'b1) busy_bad++;
      for (int i = 0; i < 4; i++)
        if (k == 2 + i * (D + 2) && key_sw_o !== 2'(i)) key_bad++;
      if (done === 1'b1) begin
        dcyc = k; p = pass; e = err_cnt; f = fail_idx;
      end
    end
    @(negedge clk);
    key_after  = key_sw_o;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; masks = 8'h00;
    repeat (3) @(negedge clk);
    n_tot++;
    if ({key_sw_o, busy, done} !== 4'b0)
      $display("FAIL reset_ctl got key=%b busy=%b done=%b want 0",
               key_sw_o, busy, done);
    else n_pass++;
    n_tot++;
    if ({pass, err_cnt, fail_idx} !== 6'b0)
      $display("FAIL reset_res got pass=%b err=%0d fidx=%0d want 0",
               pass, err_cnt, fail_idx);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({key_sw_o, busy, done} !== 4'b0)
      $display("FAIL idle_hold got key=%b busy=%b done=%b want 0",
               key_sw_o, busy, done);
    else n_pass++;
  endtask

  task automatic check_run(input string nm, input logic [7:0] m);
    int dc, kb, bb, me, mf;
    logic p, mp, ba;
    logic [2:0] e;
    logic [1:0] f, ka;
    model(m, me, mf, mp);
    do_run(m, dc, kb, bb, p, e, f, ka, ba);
    n_tot++;
    if (dc !== LAT) $display("FAIL %s_lat got %0d want %0d", nm, dc, LAT);
    else n_pass++;
    n_tot++;
    if (kb !== 0) $display("FAIL %s_keys got %0d bad want 0", nm, kb);
    else n_pass++;
    n_tot++;
    if (bb !== 0) $display("FAIL %s_busy got %0d low want 0", nm, bb);
    else n_pass++;
    n_tot++;
    if (e !== 3'(me)) $display("FAIL %s_err got %0d want %0d", nm, e, me);
    else n_pass++;
    n_tot++;
    if (f !== 2'(mf)) $display("FAIL %s_fidx got %0d want %0d", nm, f, mf);
    else n_pass++;
    n_tot++;
    if (p !== mp) $display("FAIL %s_pass got %b want %b", nm, p, mp);
    else n_pass++;
    n_tot++;
    if ({ka, ba} !== 3'b0)
      $display("FAIL %s_after got key=%b busy=%b want 0", nm, ka, ba);
    else n_pass++;
  endtask

  task automatic test_loopback();
    check_run("loop", 8'h00);
  endtask

  task automatic test_stuck_zero();
    int me, mf;
    logic mp;
    model(8'he4, me, mf, mp);
    n_tot++;
    if (me != 3 || mf != 1 || mp != 1'b0)
      $display("FAIL zero_model got err=%0d fidx=%0d want 3/1", me, mf);
    else n_pass++;
    check_run("zero", 8'he4);
  endtask

  task automatic test_invert();
    check_run("inv", 8'hff);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) check_run("rand", 8'($urandom));
  endtask

  task automatic test_mid_reset();
    int k, nd;
    @(negedge clk);
    masks = 8'h00;
    start = 1'b1;
    k = 0;
    while (k < 2 + 2 * (D + 2) + 1) begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    rst = 1'b1;
    #1;
    n_tot++;
    if ({key_sw_o, busy, done, pass, err_cnt, fail_idx} !== 10'b0)
      $display("FAIL midrst_out got key=%b busy=%b done=%b err=%0d want 0",
               key_sw_o, busy, done, err_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    n_tot++;
    if (nd !== 0) $display("FAIL midrst_quiet got %0d active want 0", nd);
    else n_pass++;
    check_run("postrst", 8'h00);
  endtask

  task automatic test_back_to_back();
    int want[$];
    int got[$];
    int k, a;
    a = 1;
    while (a <= 60) begin
      want.push_back(a + LAT - 1);
      a += LAT + 1;
    end
    @(negedge clk);
    masks = 8'h00;
    start = 1'b1;
    k = 0;
    while (k < 60 + 3 * LAT) begin
      @(negedge clk);
      k++;
      if (k == 60) start = 1'b0;
      if (done === 1'b1) got.push_back(k);
    end
    n_tot++;
    if (got.size() !== want.size())
      $display("FAIL b2b_runs got %0d want %0d", got.size(), want.size());
    else n_pass++;
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      n_tot++;
      if (got[i] !== want[i])
        $display("FAIL b2b_done%0d got %0d want %0d", i, got[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int k, nd, first;
    @(negedge clk);
    masks = 8'h00;
    start = 1'b1;
    k = 0; nd = 0; first = 0;
    while (k < 3 * LAT) begin
      @(negedge clk);
      k++;
      start = (k == 5 || k == LAT - 3 || k == LAT);
      if (done === 1'b1) begin
        nd++;
        if (first == 0) first = k;
      end
    end
    start = 1'b0;
    n_tot++;
    if (nd !== 1) $display("FAIL ignore_runs got %0d want 1", nd);
    else n_pass++;
    n_tot++;
    if (first !== LAT) $display("FAIL ignore_lat got %0d want %0d", first, LAT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck_zero();
    test_invert();
    test_random();
    test_mid_reset();
    test_back_to_back();
    test_busy_ignore();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/key_pattern_sequencer.md
Name: key_pattern_sequencer

Overview:
On-board self-test controller for the 2-key / 2-LED datapath block.
- Steps key_sw through all four patterns 00, 01, 10, 11.
- Holds each pattern for a programmable dwell time, then samples the LED response and compares it against a parameterised expected table.
- Reports pass/fail, error count and first failing pattern.
- Sits between the board buttons/start logic and the datapath instance, replacing manual key stimulus on hardware.

Parameters:
DWELL, 10, cycles each pattern is held before sampling; legal range 1..65535; elaboration error outside this range.
EXPECT, 8'b11100100, expected led per pattern; entry i = EXPECT[2i+1:2i] (default = pass-through).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  level; sampled only in IDLE; starts one test run.
led_i  input  2  LED outputs of the datapath under control.
key_sw_o  output  2  key pattern driven into the datapath.
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  one-cycle pulse at end of run.
pass  output  1  valid from done onward; 1 = zero mismatches; held until next accepted start.
err_cnt  output  3  number of mismatching patterns, 0..4.
fail_idx  output  2  index of first mismatching pattern; 0 if none.

Behaviour:
- Reset (async, any state) forces:
  - state = IDLE, pattern index = 0, dwell counter = 0
  - key_sw_o = 00, busy = 0, done = 0, pass = 0, err_cnt = 0, fail_idx = 0
- Reset mid-run aborts the run with no done pulse.

State machine:
- IDLE: key_sw_o = 00. If start = 1:
  - clear err_cnt, fail_idx, pass and index
  - go to APPLY
- APPLY (1 cycle):
  - key_sw_o <= index (pattern value equals index)
  - load dwell counter with DWELL-1
  - go to WAIT
- WAIT: decrement the counter each cycle; when counter = 0, go to CHECK. WAIT lasts exactly DWELL cycles.
- CHECK (1 cycle): compare the compared-LED value against EXPECT entry[index].
  - On mismatch: err_cnt += 1. If err_cnt was 0, fail_idx <= index.
  - If index = 3, go to DONE; else index += 1 and go to APPLY.
- DONE (1 cycle):
  - done = 1, pass = (err_cnt == 0)
  - key_sw_o <= 00
  - go to IDLE

Timing:
- Per pattern: DWELL + 2 cycles.
- done is high in cycle 4*(DWELL+2) + 1 after the start-accept edge.
- busy = 1 in APPLY, WAIT, CHECK and DONE.

Boundary rules:
- start held high continuously: a new run begins on the cycle after DONE, i.e. one IDLE cycle between runs.
- start while busy is ignored; there is no queuing.
- err_cnt cannot exceed 4; a 3-bit width suffices and no wrap occurs.
- Index arithmetic is 2-bit; the 3 -> DONE exit precedes any increment, so no wrap.

Optional Feature:
Macro LED_SYNC_EN.
- Defined: led_i passes through a 2-flop synchronizer; CHECK compares the synchronized value. Adds 2 cycles of LED sampling latency. DWELL >= 3 is enforced by elaboration check; run timing is otherwise unchanged.
- Undefined: CHECK compares led_i directly. DWELL >= 1 only.

Decomposition:
- Package key_seq_pkg holds:
  - state enum: IDLE, APPLY, WAIT, CHECK, DONE
  - PATTERN_CNT = 4
  - KEY_W = 2, ERR_W = 3
  - function returning EXPECT entry i
- Sub-module dwell_timer:
  - load, count-down, zero flag
  - counter width $clog2(DWELL+1)
  - instantiated once

Test Plan (DWELL=4 unless noted; cycles per pattern = 6):
1. Reset, then start pulse, led_i = key_sw_o looped back -> key_sw_o steps 00, 01, 10, 11 at 6-cycle intervals; done pulse 25 cycles after start accept; pass=1, err_cnt=0, fail_idx=0; key_sw_o=00 after DONE.
2. led_i forced to 00 -> mismatches on patterns 1, 2, 3; err_cnt=3, fail_idx=1, pass=0.
3. led_i = ~key_sw_o -> err_cnt=4, fail_idx=0, pass=0; no counter wrap.
4. rst asserted during WAIT of pattern 2 -> all outputs return to reset values immediately, no done pulse; a subsequent start runs a full clean run.
5. start held high for 60 cycles -> second run begins exactly 1 IDLE cycle after the first done; start pulses while busy are ignored.
6. LED_SYNC_EN defined, DWELL=3, loopback -> pass=1; done 21 cycles after start accept; DWELL=2 fails elaboration.
